// File: rtl/conway_pkg.sv
// Shared types, constants and the rule lookup used by the Game-of-Life grid engine.
package conway_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STEP   = 2'd1,
        UNLOAD = 2'd2
    } state_e;

    localparam int NBR_CNT_W = 4;

    localparam logic [8:0] DEFAULT_BIRTH   = 9'h008;
    localparam logic [8:0] DEFAULT_SURVIVE = 9'h00C;

    // Counts above 8 cannot occur, but the mask has only nine entries.
    function automatic logic ruleLookup(input logic [8:0] mask, input logic [NBR_CNT_W-1:0] cnt);
        return (cnt > 4'd8) ? 1'b0 : mask[cnt];
    endfunction

endpackage

// File: rtl/conway_row_next.sv
// Combinational next-generation row from the rows above, at and below it.
module conway_row_next
    import conway_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WRAP  = 0
) (
    input  logic [WIDTH-1:0] rowAbove_i,
    input  logic [WIDTH-1:0] rowCur_i,
    input  logic [WIDTH-1:0] rowBelow_i,
    input  logic [8:0]       birth_i,
    input  logic [8:0]       survive_i,
    output logic [WIDTH-1:0] nextRow_o
);

    logic [WIDTH+1:0]     extAbove;
    logic [WIDTH+1:0]     extCur;
    logic [WIDTH+1:0]     extBelow;
    logic [NBR_CNT_W-1:0] cnt;

    // Pad each row by one column per side so every cell sees the same window.
    function automatic logic [WIDTH+1:0] padRow(input logic [WIDTH-1:0] row);
        if (WRAP != 0) begin
            return {row[0], row, row[WIDTH-1]};
        end
        return {1'b0, row, 1'b0};
    endfunction

    assign extAbove = padRow(rowAbove_i);
    assign extCur   = padRow(rowCur_i);
    assign extBelow = padRow(rowBelow_i);

    always_comb begin
        nextRow_o = '0;
        cnt       = '0;
        for (int c = 0; c < WIDTH; c++) begin
            cnt = NBR_CNT_W'(extAbove[c]) + NBR_CNT_W'(extAbove[c+1]) + NBR_CNT_W'(extAbove[c+2])
                + NBR_CNT_W'(extCur[c])                               + NBR_CNT_W'(extCur[c+2])
                + NBR_CNT_W'(extBelow[c]) + NBR_CNT_W'(extBelow[c+1]) + NBR_CNT_W'(extBelow[c+2]);
            nextRow_o[c] = extCur[c+1] ? ruleLookup(survive_i, cnt) : ruleLookup(birth_i, cnt);
        end
    end

endmodule

// File: rtl/conway_grid.sv
// Double-buffered Game-of-Life engine: load a frame, step N generations, unload it.
// Define CONWAY_RULE_PROG_EN to add programmable birth/survive rule ports.
module conway_grid
    import conway_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WRAP   = 0,
    parameter int GEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_row,
    input  logic [GEN_W-1:0]  in_gens,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_row,
    output logic              out_last,
    output logic              busy
`ifdef CONWAY_RULE_PROG_EN
    ,
    input  logic [8:0]        rule_birth,
    input  logic [8:0]        rule_survive
`endif
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [GEN_W-1:0]   remaining_q, remaining_d;
    logic               bufSel_q, bufSel_d;
    logic [WIDTH-1:0]   grid_q [2][HEIGHT];

    logic               lastRow;
    logic [ROW_W-1:0]   rowUp;
    logic [ROW_W-1:0]   rowDown;
    logic [WIDTH-1:0]   aboveRow;
    logic [WIDTH-1:0]   curRow;
    logic [WIDTH-1:0]   belowRow;
    logic [WIDTH-1:0]   nextRow;
    logic [8:0]         birthMask;
    logic [8:0]         surviveMask;

    assign lastRow = (row_q == LAST_ROW);
    assign rowUp   = (row_q == '0) ? LAST_ROW : row_q - 1'b1;
    assign rowDown = lastRow ? '0 : row_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        remaining_d = remaining_q;
        bufSel_d    = bufSel_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    row_d = rowDown;
                    if (row_q == '0) begin
                        remaining_d = in_gens;
                    end
                    if (lastRow) begin
                        state_d = (remaining_q != '0) ? STEP : UNLOAD;
                    end
                end
            end
            STEP: begin
                row_d = rowDown;
                if (lastRow) begin
                    bufSel_d    = ~bufSel_q;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == GEN_W'(1)) begin
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    row_d = rowDown;
                    if (lastRow) begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            row_q       <= '0;
            remaining_q <= '0;
            bufSel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            remaining_q <= remaining_d;
            bufSel_q    <= bufSel_d;
        end
    end

`ifdef CONWAY_RULE_PROG_EN
    logic [8:0] birth_q;
    logic [8:0] survive_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            birth_q   <= DEFAULT_BIRTH;
            survive_q <= DEFAULT_SURVIVE;
        end else if (state_q == LOAD && in_valid && row_q == '0) begin
            birth_q   <= rule_birth;
            survive_q <= rule_survive;
        end
    end

    assign birthMask   = birth_q;
    assign surviveMask = survive_q;
`else
    assign birthMask   = DEFAULT_BIRTH;
    assign surviveMask = DEFAULT_SURVIVE;
`endif

    // Frame storage is deliberately left out of reset; a new load overwrites it.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_valid) begin
            grid_q[bufSel_q][row_q] <= in_row;
        end else if (state_q == STEP) begin
            grid_q[~bufSel_q][row_q] <= nextRow;
        end
    end

    assign curRow   = grid_q[bufSel_q][row_q];
    assign aboveRow = (row_q == '0 && WRAP == 0) ? '0 : grid_q[bufSel_q][rowUp];
    assign belowRow = (lastRow && WRAP == 0) ? '0 : grid_q[bufSel_q][rowDown];

    conway_row_next #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) uRowNext (
        .rowAbove_i (aboveRow),
        .rowCur_i   (curRow),
        .rowBelow_i (belowRow),
        .birth_i    (birthMask),
        .survive_i  (surviveMask),
        .nextRow_o  (nextRow)
    );

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == UNLOAD);
    assign busy      = (state_q == STEP);
    assign out_row   = curRow;
    assign out_last  = (state_q == UNLOAD) && lastRow;

endmodule

// File: tb/tb_conway_grid.sv
// Drives two 8x8 grids (WRAP=0 and WRAP=1) in lockstep and checks them against a cell-level life model.
module tb_conway_grid;

    localparam int W = 8;
    localparam int H = 8;

    typedef logic [H-1:0][W-1:0] frame_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic [W-1:0] inRow;
    logic [7:0]   inGens;
    logic         outReady;
    logic [8:0]   modelBirth;
    logic [8:0]   modelSurvive;

    logic         inReady0, outValid0, outLast0, busy0;
    logic [W-1:0] outRow0;
    logic         inReady1, outValid1, outLast1, busy1;
    logic [W-1:0] outRow1;

`ifdef CONWAY_RULE_PROG_EN
    logic [8:0]   ruleBirthIn;
    logic [8:0]   ruleSurviveIn;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    conway_grid #(.WIDTH(W), .HEIGHT(H), .WRAP(0), .GEN_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady0), .in_row(inRow), .in_gens(inGens),
        .out_valid(outValid0), .out_ready(outReady), .out_row(outRow0), .out_last(outLast0),
        .busy(busy0)
`ifdef CONWAY_RULE_PROG_EN
        , .rule_birth(ruleBirthIn), .rule_survive(ruleSurviveIn)
`endif
    );

    conway_grid #(.WIDTH(W), .HEIGHT(H), .WRAP(1), .GEN_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady1), .in_row(inRow), .in_gens(inGens),
        .out_valid(outValid1), .out_ready(outReady), .out_row(outRow1), .out_last(outLast1),
        .busy(busy1)
`ifdef CONWAY_RULE_PROG_EN
        , .rule_birth(ruleBirthIn), .rule_survive(ruleSurviveIn)
`endif
    );

    // Reference model: count the eight neighbours of each cell directly on the grid.
    function automatic int neighbours(frame_t f, int r, int c, bit wrap);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr;
                int cc;
                rr = r + dr;
                cc = c + dc;
                if (dr == 0 && dc == 0) continue;
                if (wrap) begin
                    rr = (rr + H) % H;
                    cc = (cc + W) % W;
                end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
                    continue;
                end
                n += int'(f[rr][cc]);
            end
        end
        return n;
    endfunction

    function automatic frame_t golden(frame_t f, int gens, bit wrap, logic [8:0] b, logic [8:0] s);
        frame_t cur = f;
        for (int g = 0; g < gens; g++) begin
            frame_t nxt;
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    int n;
                    n = neighbours(cur, r, c, wrap);
                    nxt[r][c] = cur[r][c] ? s[n] : b[n];
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    function automatic frame_t randFrame();
        frame_t f;
        for (int r = 0; r < H; r++) f[r] = W'($urandom);
        return f;
    endfunction

    task automatic loadFrame(input frame_t f, input int gens, output int errs);
        errs = 0;
        for (int r = 0; r < H; r++) begin
            inValid = 1'b1;
            inRow   = f[r];
            inGens  = (r == 0) ? 8'(gens) : 8'($urandom);
`ifdef CONWAY_RULE_PROG_EN
            ruleBirthIn   = (r == 0) ? modelBirth   : 9'($urandom);
            ruleSurviveIn = (r == 0) ? modelSurvive : 9'($urandom);
`endif
            if (inReady0 !== 1'b1 || inReady1 !== 1'b1) errs++;
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        inRow   = W'($urandom);
    endtask

    task automatic collectFrame(input int gens, input bit randReady,
                                output frame_t got0, output frame_t got1,
                                output int busyCycles, output int protoErrs);
        int     cyc = 0;
        int     limit;
        int     idx0 = 0;
        int     idx1 = 0;
        bit     stall0 = 0;
        bit     stall1 = 0;
        logic [W-1:0] prev0 = '0;
        logic [W-1:0] prev1 = '0;
        got0       = '0;
        got1       = '0;
        busyCycles = 0;
        protoErrs  = 0;
        limit      = gens * H + 400;
        while (!outValid0 && cyc < limit) begin
            if (busy0) busyCycles++;
            if (busy1 !== busy0) protoErrs++;
            @(posedge clk); #1;
            cyc++;
        end
        while ((idx0 < H || idx1 < H) && cyc < limit) begin
            outReady = randReady ? 1'($urandom) : 1'b1;
            if (stall0 && outRow0 !== prev0) protoErrs++;
            if (stall1 && outRow1 !== prev1) protoErrs++;
            if (busy0 || busy1) protoErrs++;
            if (outValid0 && outReady && idx0 < H) begin
                got0[idx0] = outRow0;
                if (outLast0 !== (idx0 == H - 1)) protoErrs++;
                idx0++;
                stall0 = 0;
            end else begin
                stall0 = outValid0;
            end
            if (outValid1 && outReady && idx1 < H) begin
                got1[idx1] = outRow1;
                if (outLast1 !== (idx1 == H - 1)) protoErrs++;
                idx1++;
                stall1 = 0;
            end else begin
                stall1 = outValid1;
            end
            prev0 = outRow0;
            prev1 = outRow1;
            @(posedge clk); #1;
            cyc++;
        end
        outReady = 1'b0;
        if (idx0 < H || idx1 < H) protoErrs += 100;
        if (inReady0 !== 1'b1 || inReady1 !== 1'b1 || outValid0 !== 1'b0) protoErrs++;
    endtask

    task automatic runFrame(input frame_t f, input int gens, input bit randReady,
                            output frame_t got0, output frame_t got1,
                            output int busyCycles, output int errs);
        int loadErrs;
        int protoErrs;
        loadFrame(f, gens, loadErrs);
        collectFrame(gens, randReady, got0, got1, busyCycles, protoErrs);
        errs = loadErrs + protoErrs;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        inRow    = '0;
        inGens   = '0;
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if ({inReady0, outValid0, busy0, outLast0} !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL reset_dut0: got rdy/vld/busy/last=%b expected 1000",
                     {inReady0, outValid0, busy0, outLast0});
        end
        testsRun++;
        if ({inReady1, outValid1, busy1, outLast1} !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL reset_dut1: got rdy/vld/busy/last=%b expected 1000",
                     {inReady1, outValid1, busy1, outLast1});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_blinker();
        frame_t f, exp1, got0, got1;
        int busyCycles, errs;
        f = '0;
        f[3] = 8'b0001_1100;
        exp1 = '0;
        exp1[2] = 8'b0000_1000;
        exp1[3] = 8'b0000_1000;
        exp1[4] = 8'b0000_1000;
        runFrame(f, 1, 1'b0, got0, got1, busyCycles, errs);
        testsRun++;
        if (got0 !== exp1) begin
            testsFailed++;
            $display("[TB] FAIL blinker_g1: got %h expected %h", got0, exp1);
        end
        testsRun++;
        if (busyCycles !== H || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL blinker_g1_proto: busy=%0d errs=%0d expected busy=%0d errs=0", busyCycles, errs, H);
        end
        runFrame(f, 2, 1'b0, got0, got1, busyCycles, errs);
        testsRun++;
        if (got0 !== f || got1 !== f) begin
            testsFailed++;
            $display("[TB] FAIL blinker_g2: got %h / %h expected %h", got0, got1, f);
        end
        testsRun++;
        if (busyCycles !== 2 * H || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL blinker_g2_proto: busy=%0d errs=%0d expected busy=%0d errs=0", busyCycles, errs, 2 * H);
        end
    endtask

    task automatic test_glider();
        frame_t f, got0, got1, exp0;
        int busyCycles, errs;
        f = '0;
        f[0] = 8'b0000_0010;
        f[1] = 8'b0000_0100;
        f[2] = 8'b0000_0111;
        exp0 = golden(f, 32, 1'b0, modelBirth, modelSurvive);
        runFrame(f, 32, 1'b0, got0, got1, busyCycles, errs);
        testsRun++;
        if (got1 !== f) begin
            testsFailed++;
            $display("[TB] FAIL glider_wrap: got %h expected %h", got1, f);
        end
        testsRun++;
        if (got0 !== exp0) begin
            testsFailed++;
            $display("[TB] FAIL glider_nowrap: got %h expected %h", got0, exp0);
        end
        testsRun++;
        if (busyCycles !== 256 || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL glider_busy: busy=%0d errs=%0d expected busy=256 errs=0", busyCycles, errs);
        end
    endtask

    task automatic test_passthrough();
        frame_t f, got0, got1;
        int busyCycles, errs;
        f = randFrame();
        runFrame(f, 0, 1'b1, got0, got1, busyCycles, errs);
        testsRun++;
        if (got0 !== f || got1 !== f) begin
            testsFailed++;
            $display("[TB] FAIL passthrough: got %h / %h expected %h", got0, got1, f);
        end
        testsRun++;
        if (busyCycles !== 0 || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL passthrough_busy: busy=%0d errs=%0d expected 0 and 0", busyCycles, errs);
        end
    endtask

    task automatic test_backpressure();
        frame_t f, got0, got1;
        int busyCycles, errs;
        f = '0;
        f[3] = 8'b0001_1000;
        f[4] = 8'b0001_1000;
        runFrame(f, 255, 1'b1, got0, got1, busyCycles, errs);
        testsRun++;
        if (got0 !== f || got1 !== f) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_block: got %h / %h expected %h", got0, got1, f);
        end
        testsRun++;
        if (busyCycles !== 255 * H || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_stall: busy=%0d errs=%0d expected busy=%0d errs=0", busyCycles, errs, 255 * H);
        end
    endtask

    task automatic test_random();
        frame_t f, got0, got1, exp0, exp1;
        int busyCycles, errs, gens;
        for (int i = 0; i < 5; i++) begin
            f    = randFrame();
            gens = int'($urandom_range(1, 5));
            exp0 = golden(f, gens, 1'b0, modelBirth, modelSurvive);
            exp1 = golden(f, gens, 1'b1, modelBirth, modelSurvive);
            runFrame(f, gens, 1'b1, got0, got1, busyCycles, errs);
            testsRun++;
            if (got0 !== exp0 || got1 !== exp1 || errs !== 0 || busyCycles !== gens * H) begin
                testsFailed++;
                $display("[TB] FAIL random_%0d: got %h / %h errs=%0d busy=%0d expected %h / %h errs=0 busy=%0d",
                         i, got0, got1, errs, busyCycles, exp0, exp1, gens * H);
            end
        end
    endtask

    task automatic test_reset_mid_step();
        frame_t f, got0, got1, exp0, exp1;
        int busyCycles, errs;
        f = randFrame();
        loadFrame(f, 10, errs);
        repeat (13) @(posedge clk);
        #1;
        testsRun++;
        if (busy0 !== 1'b1 || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midstep_busy: busy=%b errs=%0d expected 1 and 0", busy0, errs);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        testsRun++;
        if ({inReady0, outValid0, busy0, inReady1, outValid1, busy1} !== 6'b100100) begin
            testsFailed++;
            $display("[TB] FAIL midstep_reset: got %b expected 100100",
                     {inReady0, outValid0, busy0, inReady1, outValid1, busy1});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        testsRun++;
        if ({inReady0, outValid0, busy0} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL midstep_after: got %b expected 100", {inReady0, outValid0, busy0});
        end
        f    = randFrame();
        exp0 = golden(f, 3, 1'b0, modelBirth, modelSurvive);
        exp1 = golden(f, 3, 1'b1, modelBirth, modelSurvive);
        runFrame(f, 3, 1'b1, got0, got1, busyCycles, errs);
        testsRun++;
        if (got0 !== exp0 || got1 !== exp1 || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midstep_newframe: got %h / %h errs=%0d expected %h / %h errs=0",
                     got0, got1, errs, exp0, exp1);
        end
    endtask

`ifdef CONWAY_RULE_PROG_EN
    task automatic test_rules();
        frame_t f, got0, got1, exp0, exp1;
        int busyCycles, errs;
        modelBirth   = 9'h048;
        modelSurvive = 9'h00C;
        f = '0;
        f[1] = 8'h38;
        f[2] = 8'h24;
        f[3] = 8'h22;
        f[4] = 8'h12;
        f[5] = 8'h0E;
        exp0 = golden(f, 12, 1'b0, modelBirth, modelSurvive);
        exp1 = golden(f, 12, 1'b1, modelBirth, modelSurvive);
        runFrame(f, 12, 1'b1, got0, got1, busyCycles, errs);
        testsRun++;
        if (got0 !== exp0 || got1 !== exp1 || errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL highlife: got %h / %h errs=%0d expected %h / %h errs=0",
                     got0, got1, errs, exp0, exp1);
        end
        modelBirth   = 9'h008;
        modelSurvive = 9'h00C;
    endtask
`endif

    initial begin
        modelBirth   = 9'h008;
        modelSurvive = 9'h00C;
`ifdef CONWAY_RULE_PROG_EN
        ruleBirthIn   = 9'h008;
        ruleSurviveIn = 9'h00C;
`endif
        test_reset();
        test_blinker();
        test_glider();
        test_passthrough();
        test_backpressure();
        test_random();
        test_reset_mid_step();
`ifdef CONWAY_RULE_PROG_EN
        test_rules();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
